// File: rtl/mips_debug_unit_pkg.sv
// Shared constants, state encodings and command decode for the MIPS host debug unit.
package mips_debug_pkg;

    localparam logic [7:0] CMD_LOAD = 8'h4C;
    localparam logic [7:0] CMD_RUN  = 8'h43;
    localparam logic [7:0] CMD_STEP = 8'h53;
    localparam logic [7:0] CMD_DUMP = 8'h44;

    localparam logic [31:0] HALT_INST  = 32'h0000_0000;
    localparam int          DUMP_WORDS = 33;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_LOAD       = 3'd1,
        ST_RUN        = 3'd2,
        ST_STEP       = 3'd3,
        ST_DUMP_LATCH = 3'd4,
        ST_DUMP_SEND  = 3'd5,
        ST_DUMP_WAIT  = 3'd6
    } dbg_state_t;

    typedef enum logic [0:0] {
        SER_IDLE = 1'b0,
        SER_WAIT = 1'b1
    } ser_state_t;

    // Unknown command bytes map to IDLE so they leave the FSM where it is.
    function automatic dbg_state_t decode_cmd(input logic [7:0] cmd);
        case (cmd)
            CMD_LOAD: return ST_LOAD;
            CMD_RUN:  return ST_RUN;
            CMD_STEP: return ST_STEP;
            CMD_DUMP: return ST_DUMP_LATCH;
            default:  return ST_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/mips_debug_unit_if.sv
// Bundle of UART, instruction-load and CPU-debug signals around the debug unit.
interface mips_debug_unit_if #(
    parameter int NB_ADDR = 32,
    parameter int NB_INST = 32,
    parameter int NB_DATA = 32,
    parameter int NB_REG  = 5,
    parameter int NB_BYTE = 8
);
    logic [NB_BYTE-1:0] i_rx_data;
    logic               i_rx_valid;
    logic [NB_BYTE-1:0] o_tx_data;
    logic               o_tx_start;
    logic               i_tx_done;
    logic               o_write;
    logic [NB_ADDR-1:0] o_address;
    logic [NB_INST-1:0] o_instruction;
    logic               o_enable;
    logic [NB_ADDR-1:0] i_pc;
    logic               i_halt;
    logic [NB_REG-1:0]  o_reg_addr;
    logic [NB_DATA-1:0] i_reg_data;
    logic               o_busy;

    modport master (
        input  i_rx_data, i_rx_valid, i_tx_done, i_pc, i_halt, i_reg_data,
        output o_tx_data, o_tx_start, o_write, o_address, o_instruction,
               o_enable, o_reg_addr, o_busy
    );

    modport slave (
        output i_rx_data, i_rx_valid, i_tx_done, i_pc, i_halt, i_reg_data,
        input  o_tx_data, o_tx_start, o_write, o_address, o_instruction,
               o_enable, o_reg_addr, o_busy
    );
endinterface

// File: rtl/mips_debug_unit_serializer.sv
// Sends one word over the byte-wide tx handshake, least significant byte first.
module dbg_word_serializer
    import mips_debug_pkg::*;
#(
    parameter int NB_WORD = 32,
    parameter int NB_BYTE = 8
) (
    input  logic               clk,
    input  logic               rst_b,
    input  logic [NB_WORD-1:0] word,
    input  logic               start,
    output logic               done,
    output logic [NB_BYTE-1:0] tx_data,
    output logic               tx_start,
    input  logic               tx_done
);
    localparam int                NB_CNT    = $clog2(NB_WORD / NB_BYTE);
    localparam logic [NB_CNT-1:0] LAST_BYTE = NB_CNT'(NB_WORD / NB_BYTE - 1);

    ser_state_t         state_q, state_d;
    logic [NB_WORD-1:0] shift_q;
    logic [NB_CNT-1:0]  cnt_q;
    logic               load, advance, finish;

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        advance = 1'b0;
        finish  = 1'b0;
        case (state_q)
            SER_IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = SER_WAIT;
                end
            end
            SER_WAIT: begin
                if (tx_done) begin
                    if (cnt_q == LAST_BYTE) begin
                        finish  = 1'b1;
                        state_d = SER_IDLE;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            default: state_d = SER_IDLE;
        endcase
    end

    // tx_data only changes together with a start pulse, so it holds through each byte.
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            state_q  <= SER_IDLE;
            shift_q  <= '0;
            cnt_q    <= '0;
            tx_data  <= '0;
            tx_start <= 1'b0;
            done     <= 1'b0;
        end else begin
            state_q  <= state_d;
            tx_start <= load | advance;
            done     <= finish;
            if (load) begin
                tx_data <= word[NB_BYTE-1:0];
                shift_q <= word >> NB_BYTE;
                cnt_q   <= '0;
            end else if (advance) begin
                tx_data <= shift_q[NB_BYTE-1:0];
                shift_q <= shift_q >> NB_BYTE;
                cnt_q   <= cnt_q + NB_CNT'(1);
            end
        end
    end

endmodule

// File: rtl/mips_debug_unit.sv
// Host debug controller: loads program words over UART, runs or steps the CPU,
// then streams PC and the register file back out.
//
//   state       | meaning
//   IDLE        | waiting for a command byte
//   LOAD        | assembling bytes into words and writing instruction memory
//   RUN         | CPU enabled until HALT retires
//   STEP        | CPU enabled for a single cycle
//   DUMP_LATCH  | capture PC or the addressed register into the send buffer
//   DUMP_SEND   | kick the serializer with the captured word
//   DUMP_WAIT   | wait for the serializer to finish the word
module mips_debug_unit
    import mips_debug_pkg::*;
#(
    parameter int NB_ADDR    = 32,
    parameter int NB_INST    = 32,
    parameter int NB_DATA    = 32,
    parameter int NB_REG     = 5,
    parameter int NB_BYTE    = 8,
    parameter int IMEM_DEPTH = 64
) (
    input  logic               i_clk,
    input  logic               i_reset,
    mips_debug_unit_if.master  bus
);
    localparam logic [NB_ADDR-1:0] LAST_ADDR = NB_ADDR'((IMEM_DEPTH - 1) * 4);
    localparam logic [5:0]         LAST_WORD = 6'(DUMP_WORDS - 1);

    dbg_state_t                 state_q, state_d;
    logic [1:0]                 byte_cnt_q;
    logic [NB_INST-NB_BYTE-1:0] inst_buf_q;
    logic [NB_INST-1:0]         assembled;
    logic [NB_ADDR-1:0]         addr_cnt_q;
    logic [NB_ADDR-1:0]         pc_q;
    logic [5:0]                 word_idx_q;
    logic [NB_DATA-1:0]         word_q;

    logic load_byte, word_done, load_exit;
    logic dump_entry, latch_word, ser_start, next_word, ser_done;

    assign assembled  = {bus.i_rx_data, inst_buf_q};
    assign bus.o_busy = (state_q != ST_IDLE);

    always_comb begin
        state_d    = state_q;
        load_byte  = 1'b0;
        word_done  = 1'b0;
        load_exit  = 1'b0;
        latch_word = 1'b0;
        ser_start  = 1'b0;
        next_word  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.i_rx_valid) state_d = decode_cmd(bus.i_rx_data);
            end
            ST_LOAD: begin
                if (bus.i_rx_valid) begin
                    load_byte = 1'b1;
                    if (byte_cnt_q == 2'd3) begin
                        word_done = 1'b1;
                        if (assembled == HALT_INST || addr_cnt_q == LAST_ADDR) begin
                            load_exit = 1'b1;
                            state_d   = ST_IDLE;
                        end
                    end
                end
            end
            ST_RUN: begin
                if (bus.i_halt) state_d = ST_DUMP_LATCH;
            end
            ST_STEP: state_d = ST_DUMP_LATCH;
            ST_DUMP_LATCH: begin
                latch_word = 1'b1;
                state_d    = ST_DUMP_SEND;
            end
            ST_DUMP_SEND: begin
                ser_start = 1'b1;
                state_d   = ST_DUMP_WAIT;
            end
            ST_DUMP_WAIT: begin
                if (ser_done) begin
                    if (word_idx_q == LAST_WORD) begin
                        state_d = ST_IDLE;
                    end else begin
                        next_word = 1'b1;
                        state_d   = ST_DUMP_LATCH;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign dump_entry = (state_d == ST_DUMP_LATCH) &&
                        (state_q inside {ST_IDLE, ST_RUN, ST_STEP});

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state_q           <= ST_IDLE;
            byte_cnt_q        <= '0;
            inst_buf_q        <= '0;
            addr_cnt_q        <= '0;
            pc_q              <= '0;
            word_idx_q        <= '0;
            word_q            <= '0;
            bus.o_write       <= 1'b0;
            bus.o_address     <= '0;
            bus.o_instruction <= '0;
            bus.o_enable      <= 1'b0;
            bus.o_reg_addr    <= '0;
        end else begin
            state_q      <= state_d;
            bus.o_enable <= (state_d == ST_RUN) || (state_d == ST_STEP);
            bus.o_write  <= word_done;

            if (load_byte) begin
                byte_cnt_q <= byte_cnt_q + 2'd1;
                case (byte_cnt_q)
                    2'd0:    inst_buf_q[NB_BYTE-1:0]           <= bus.i_rx_data;
                    2'd1:    inst_buf_q[2*NB_BYTE-1:NB_BYTE]   <= bus.i_rx_data;
                    2'd2:    inst_buf_q[3*NB_BYTE-1:2*NB_BYTE] <= bus.i_rx_data;
                    default: ;
                endcase
            end

            if (word_done) begin
                bus.o_address     <= addr_cnt_q;
                bus.o_instruction <= assembled;
                addr_cnt_q        <= load_exit ? '0 : addr_cnt_q + NB_ADDR'(4);
            end

            if (dump_entry) begin
                pc_q       <= bus.i_pc;
                word_idx_q <= '0;
            end

            // Point the register port at the next word's register while this one is
            // being shifted out, so read data has long settled by the next latch.
            if (latch_word) begin
                word_q <= (word_idx_q == '0) ? NB_DATA'(pc_q) : bus.i_reg_data;
                if (word_idx_q < LAST_WORD) bus.o_reg_addr <= NB_REG'(word_idx_q);
            end

            if (next_word) word_idx_q <= word_idx_q + 6'd1;
        end
    end

    dbg_word_serializer #(
        .NB_WORD (NB_DATA),
        .NB_BYTE (NB_BYTE)
    ) u_serializer (
        .clk      (i_clk),
        .rst_b    (i_reset),
        .word     (word_q),
        .start    (ser_start),
        .done     (ser_done),
        .tx_data  (bus.o_tx_data),
        .tx_start (bus.o_tx_start),
        .tx_done  (bus.i_tx_done)
    );

endmodule

// File: tb/tb_mips_debug_unit.sv
// Scoreboard bench: stimulus pushes expected writes/tx bytes, monitors pop and compare.
module tb_mips_debug_unit;
    import mips_debug_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mips_debug_unit_if bus ();
    mips_debug_unit dut (.i_clk(clk), .i_reset(rst_n), .bus(bus));

    int          tests    = 0;
    int          failed   = 0;
    int          tx_delay = 2;
    int          en_count = 0;
    logic [7:0]  exp_tx[$];
    logic [63:0] exp_wr[$];
    logic [31:0] regs[32];
    logic        tx_inflight = 1'b0;
    logic [7:0]  tx_held     = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Register file with one cycle of read latency.
    always @(posedge clk) bus.i_reg_data <= regs[bus.o_reg_addr];

    // UART transmitter model.
    initial begin
        bus.i_tx_done = 1'b0;
        forever begin
            if (bus.o_tx_start === 1'b1) begin
                repeat (tx_delay) @(negedge clk);
                bus.i_tx_done = 1'b1;
                @(negedge clk);
                bus.i_tx_done = 1'b0;
            end else begin
                @(negedge clk);
            end
        end
    end

    // Monitors: sample just after each rising edge.
    always @(posedge clk) begin
        #1;
        if (bus.o_enable === 1'b1) en_count++;
        if (bus.o_write === 1'b1) begin
            if (exp_wr.size() == 0) begin
                tests++;
                failed++;
                $display("FAIL wr_unexpected: addr %h instr %h with none expected",
                         bus.o_address, bus.o_instruction);
            end else begin
                logic [63:0] e;
                e = exp_wr.pop_front();
                check("wr_addr", bus.o_address, e[63:32]);
                check("wr_instr", bus.o_instruction, e[31:0]);
            end
        end
        if (bus.i_tx_done === 1'b1) tx_inflight = 1'b0;
        if (bus.o_tx_start === 1'b1) begin
            check("tx_overlap", {31'd0, tx_inflight}, 32'd0);
            if (exp_tx.size() == 0) begin
                tests++;
                failed++;
                $display("FAIL tx_unexpected: byte %h with none expected", bus.o_tx_data);
            end else begin
                logic [7:0] b;
                b = exp_tx.pop_front();
                check("tx_byte", {24'd0, bus.o_tx_data}, {24'd0, b});
            end
            tx_inflight = 1'b1;
            tx_held     = bus.o_tx_data;
        end else if (tx_inflight) begin
            check("tx_hold", {24'd0, bus.o_tx_data}, {24'd0, tx_held});
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        bus.i_rx_data  = b;
        bus.i_rx_valid = 1'b1;
        @(negedge clk);
        bus.i_rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
    endtask

    task automatic push_dump(input logic [31:0] pc);
        logic [31:0] w;
        for (int i = 0; i < 4; i++) exp_tx.push_back(pc[8*i +: 8]);
        for (int r = 0; r < 32; r++) begin
            w = regs[r];
            for (int i = 0; i < 4; i++) exp_tx.push_back(w[8*i +: 8]);
        end
    endtask

    task automatic wait_idle(input string name, input int limit);
        int n;
        n = 0;
        while (bus.o_busy !== 1'b0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        check(name, {31'd0, bus.o_busy}, 32'd0);
    endtask

    task automatic check_outputs_zero();
        check("rst_write",   {31'd0, bus.o_write},    32'd0);
        check("rst_txstart", {31'd0, bus.o_tx_start}, 32'd0);
        check("rst_enable",  {31'd0, bus.o_enable},   32'd0);
        check("rst_busy",    {31'd0, bus.o_busy},     32'd0);
        check("rst_address", bus.o_address,           32'd0);
        check("rst_instr",   bus.o_instruction,       32'd0);
        check("rst_regaddr", {27'd0, bus.o_reg_addr}, 32'd0);
        check("rst_txdata",  {24'd0, bus.o_tx_data}, 32'd0);
    endtask

    initial begin
        int n;
        logic [31:0] word;
        bus.i_rx_data  = 8'h00;
        bus.i_rx_valid = 1'b0;
        bus.i_pc       = 32'd0;
        bus.i_halt     = 1'b0;
        for (int r = 0; r < 32; r++) regs[r] = {8'(r), 8'hC3, 8'(r * 7), 8'h5A};

        repeat (3) @(negedge clk);
        check_outputs_zero();
        rst_n = 1'b1;

        // Two-word load ending on HALT.
        exp_wr.push_back({32'd0, 32'h0022_1820});
        exp_wr.push_back({32'd4, 32'h0000_0000});
        send_byte(CMD_LOAD);
        send_word(32'h0022_1820);
        send_word(32'h0000_0000);
        @(negedge clk);
        check("load_busy", {31'd0, bus.o_busy}, 32'd0);
        check("load_wr_left", exp_wr.size(), 32'd0);

        // Unknown command byte leaves the unit idle.
        send_byte(8'h7A);
        check("bad_cmd_busy", {31'd0, bus.o_busy}, 32'd0);
        repeat (3) @(negedge clk);
        check("bad_cmd_busy2", {31'd0, bus.o_busy}, 32'd0);

        // Full-depth load auto-terminates after 64 words.
        send_byte(CMD_LOAD);
        for (int w = 0; w < 64; w++) begin
            word = {8'h80, 8'(w), 8'(w + 1), 8'hF0};
            exp_wr.push_back({32'(w * 4), word});
            send_word(word);
        end
        check("auto_busy", {31'd0, bus.o_busy}, 32'd0);
        check("auto_wr_left", exp_wr.size(), 32'd0);

        // Next byte is a command; bytes arriving during the dump are dropped.
        bus.i_pc = 32'h0000_00FC;
        push_dump(bus.i_pc);
        send_byte(CMD_DUMP);
        check("dump_cmd_busy", {31'd0, bus.o_busy}, 32'd1);
        send_byte(CMD_LOAD);
        for (int i = 0; i < 4; i++) send_byte(8'h00);
        wait_idle("dump_idle", 3000);
        check("dump_tx_left", exp_tx.size(), 32'd0);
        check("dump_wr_left", exp_wr.size(), 32'd0);

        // Run: halt seen on the tenth enabled cycle.
        bus.i_pc = 32'h0000_0120;
        regs[2]  = 32'hDEAD_BEEF;
        push_dump(bus.i_pc);
        en_count = 0;
        send_byte(CMD_RUN);
        n = 0;
        while (bus.o_enable !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("run_enable_seen", {31'd0, bus.o_enable}, 32'd1);
        repeat (9) @(negedge clk);
        bus.i_halt = 1'b1;
        wait_idle("run_idle", 3000);
        check("run_enable_cycles", en_count, 32'd10);
        check("run_tx_left", exp_tx.size(), 32'd0);

        // Run with halt already high: one enabled cycle.
        bus.i_pc = 32'h0000_0044;
        push_dump(bus.i_pc);
        en_count = 0;
        send_byte(CMD_RUN);
        wait_idle("runhalt_idle", 3000);
        check("runhalt_enable_cycles", en_count, 32'd1);
        check("runhalt_tx_left", exp_tx.size(), 32'd0);
        bus.i_halt = 1'b0;

        // Single step with a slow transmitter.
        tx_delay = 20;
        bus.i_pc = 32'h0000_0088;
        regs[31] = 32'h1234_5678;
        push_dump(bus.i_pc);
        en_count = 0;
        send_byte(CMD_STEP);
        wait_idle("step_idle", 8000);
        check("step_enable_cycles", en_count, 32'd1);
        check("step_tx_left", exp_tx.size(), 32'd0);
        tx_delay = 2;

        // Reset in the middle of a word discards the partial instruction.
        send_byte(CMD_LOAD);
        send_byte(8'hAA);
        send_byte(8'hBB);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_outputs_zero();
        exp_wr.push_back({32'd0, 32'h1122_3344});
        exp_wr.push_back({32'd4, 32'h0000_0000});
        send_byte(CMD_LOAD);
        send_word(32'h1122_3344);
        send_word(32'h0000_0000);
        @(negedge clk);
        check("reload_busy", {31'd0, bus.o_busy}, 32'd0);
        check("reload_wr_left", exp_wr.size(), 32'd0);

        repeat (5) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/mips_debug_unit.md
# mips_debug_unit

Host-side debug controller for the MIPS pipeline. It receives command and program bytes from a UART receiver, assembles 32-bit instructions, and writes them into instruction memory through the CPU load port. It then controls CPU execution in continuous or single-step mode and streams PC plus all 32 registers back through a UART transmitter. It sits between the UART pair and `top_mips`, and drives that block's `i_enable`, `i_write`, `i_address`, `i_instruction` and debug-read inputs.

## Interface
- NB_ADDR, 32, instruction-memory byte address width
- NB_INST, 32, instruction width
- NB_DATA, 32, register data width
- NB_REG, 5, register-index width
- NB_BYTE, 8, UART byte width
- IMEM_DEPTH, 64, instruction-memory depth in words; load auto-terminates after this many words

Ports:
- i_clk  in  1  clock; all logic on rising edge
- i_reset  in  1  synchronous, active-low reset
- i_rx_data  in  NB_BYTE  received byte
- i_rx_valid  in  1  one-cycle pulse, i_rx_data valid
- o_tx_data  out  NB_BYTE  byte to transmit, held stable from o_tx_start until i_tx_done
- o_tx_start  out  1  one-cycle pulse requesting transmission
- i_tx_done  in  1  one-cycle pulse, transmitter finished current byte
- o_write  out  1  instruction-memory write strobe (one cycle)
- o_address  out  NB_ADDR  instruction byte address
- o_instruction  out  NB_INST  instruction to write
- o_enable  out  1  CPU pipeline enable
- i_pc  in  NB_ADDR  current CPU PC
- i_halt  in  1  CPU has retired HALT (0x00000000); level
- o_reg_addr  out  NB_REG  debug register-read index
- i_reg_data  in  NB_DATA  register contents; valid one cycle after o_reg_addr changes
- o_busy  out  1  high in any state other than IDLE

## Operation
- Reset: all outputs 0, state IDLE, address counter 0, byte counter 0.
- IDLE: on each i_rx_valid, the byte is decoded as a command:
  - 0x4C 'L' → LOAD
  - 0x43 'C' → RUN
  - 0x53 'S' → STEP
  - 0x44 'D' → DUMP
  - Any other byte is ignored.
- LOAD:
  - Bytes are assembled little-endian, first byte → [7:0].
  - On the 4th byte, the next cycle presents o_instruction, with o_address = word_index×4, and o_write=1 for that one cycle.
  - Word index then increments.
  - Exit to IDLE after writing 0x00000000 (HALT) or after IMEM_DEPTH words, whichever comes first. The word index then resets to 0.
- RUN:
  - o_enable=1 while in RUN.
  - The cycle i_halt is sampled high, o_enable drops (registered) and the state goes to DUMP.
  - If i_halt is already high on entry, o_enable is high for exactly one cycle.
- STEP: o_enable=1 for exactly one cycle, then DUMP.
- DUMP: transmits 132 bytes, little-endian per word, in this order:
  - i_pc (latched on DUMP entry)
  - then registers 0..31
- DUMP ends in IDLE.
- i_rx_valid outside IDLE/LOAD is ignored (byte dropped).
- Arithmetic: address counter is NB_ADDR bits, increments by 4, and never exceeds (IMEM_DEPTH−1)×4. The register index counts 0..31 with no wrap beyond.

## Timing
- Command decode: state changes on the cycle after the i_rx_valid cycle.
- Load write latency: o_write asserts 1 cycle after the 4th byte's i_rx_valid. o_address and o_instruction are stable in that cycle.
- Tx handshake:
  - o_tx_start is a single-cycle pulse.
  - The next o_tx_start is no earlier than the cycle after i_tx_done.
  - o_tx_data holds its value from start to done.
- Register fetch:
  - o_reg_addr is set ≥1 cycle before the word is latched for transmit.
  - The word is latched in a LATCH state, then 4 bytes are sent.
- States: IDLE, LOAD, RUN, STEP, DUMP_LATCH, DUMP_SEND, DUMP_WAIT.
- Simultaneous i_tx_done and state exit: the done pulse is consumed, and no extra o_tx_start is generated.
- Reset mid-operation (any state): the next cycle is IDLE with all outputs 0. The partial instruction is discarded and not written.

## Structure
- Package mips_debug_pkg:
  - command byte constants CMD_LOAD/CMD_RUN/CMD_STEP/CMD_DUMP
  - state encoding
  - HALT_INST = 0
  - DUMP_WORDS = 33
- Sub-module dbg_word_serializer: takes a 32-bit word with start/done handshake, emits 4 bytes via the tx handshake, LSB first. The top FSM sequences the words.

## Test plan
- Load: 'L', then bytes 20 18 22 00 00 00 00 00 → o_write pulses twice:
  - addr 0, instr 0x00221820
  - addr 4, instr 0x00000000
  - then IDLE, o_busy=0.
- Auto-terminate: 'L', then 64 nonzero words → exactly 64 write pulses, last address 252, then IDLE. The following byte is treated as a command.
- Run: preload regs, 'C', i_halt asserted after 10 cycles → o_enable high 10 cycles. Then 132 tx bytes, first four = i_pc LE, register 2 bytes at positions 12..15.
- Step: 'S' → o_enable high exactly 1 cycle, then 132 bytes.
  - Tx model delays i_tx_done 20 cycles: no o_tx_start before each done.
- Reset mid-load: 'L', then 2 bytes, then i_reset=0 for 1 cycle → no o_write, all outputs 0. A new 'L' load starts at addr 0 with a fresh byte count.
- Invalid/ignored: byte 0x7A in IDLE → no state change; bytes received during DUMP → dump content unchanged, returns to IDLE.
